// File: rtl/fft_bitrev_buffer.sv
// -----------------------------------------------------------------------------
// fft_bitrev_buffer
//
// Streaming bit-reversal reorder buffer for the FFT datapath. Frames of
// SAMPLES words arrive in natural index order and leave in bit-reversed
// index order. Two banks are used ping-pong style, so one frame can be
// written while the previous one is read, at one sample per cycle.
//
// Parameters
//   SAMPLES     frame length, power of two, >= 2
//   ADDR_WIDTH  index width, must equal log2(SAMPLES)
//   DATA_WIDTH  sample word width
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset (partial frame discarded)
//   flush      synchronous clear of counters, bank pointers and bank flags;
//              overrides any handshake in the same cycle
//   in_data    input sample, natural order
//   in_valid   in_data valid
//   in_ready   buffer accepts in_data this cycle (registered flags only)
//   out_data   output sample, bit-reversed order
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data this cycle
//   out_last   last sample of a frame (present only with BITREV_LAST_EN)
//
// Optional feature macro: BITREV_LAST_EN adds the out_last port.
// -----------------------------------------------------------------------------
module fft_bitrev_buffer #(
  parameter int unsigned SAMPLES    = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef BITREV_LAST_EN
  ,
  output logic                  out_last
`endif
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if ((ADDR_WIDTH < 1) || (ADDR_WIDTH > 30) ||
      (SAMPLES != (32'd1 << ADDR_WIDTH))) begin : g_param_check
    $error("fft_bitrev_buffer: SAMPLES must be 2**ADDR_WIDTH and >= 2");
  end

  // ---------------------------------------------------------------------------
  // Types and state
  // ---------------------------------------------------------------------------
  // A bank is either being filled by the write side or holds a complete
  // frame. Draining is FULL with rd_bank_q pointing at it.
  typedef enum logic {
    BANK_FILLING = 1'b0,
    BANK_FULL    = 1'b1
  } bank_state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SAMPLES - 1);

  logic [DATA_WIDTH-1:0] mem_q [2][SAMPLES];

  bank_state_e           bank_q [2];
  bank_state_e           bank_d [2];
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q,  wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // ---------------------------------------------------------------------------
  // Bit reversal of the read index: bit k -> bit ADDR_WIDTH-1-k
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] idx);
    logic [ADDR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < ADDR_WIDTH; k++) begin
      r[ADDR_WIDTH-1-k] = idx[k];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshakes and outputs (all from registered state)
  // ---------------------------------------------------------------------------
  assign in_ready  = (bank_q[wr_bank_q] == BANK_FILLING);
  assign out_valid = (bank_q[rd_bank_q] == BANK_FULL);
  assign wr_fire   = in_valid  && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign rd_addr   = bitrev(rd_cnt_q);
  assign out_data  = mem_q[rd_bank_q][rd_addr];

`ifdef BITREV_LAST_EN
  assign out_last  = out_valid && (rd_cnt_q == LAST_IDX);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // The write side only touches a FILLING bank and the read side only a FULL
  // one, so a fill and a release in the same cycle always hit different banks
  // and both updates can be applied independently.
  always_comb begin
    bank_d    = bank_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    if (flush) begin
      bank_d[0] = BANK_FILLING;
      bank_d[1] = BANK_FILLING;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_cnt_d  = '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt_q == LAST_IDX) begin
          wr_cnt_d          = '0;
          bank_d[wr_bank_q] = BANK_FULL;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end

      if (rd_fire) begin
        if (rd_cnt_q == LAST_IDX) begin
          rd_cnt_d          = '0;
          bank_d[rd_bank_q] = BANK_FILLING;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q[0] <= BANK_FILLING;
      bank_q[1] <= BANK_FILLING;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  // Write and read must never own the same bank in one cycle.
  a_bank_exclusive : assert property (
    @(posedge clk) disable iff (!reset_n)
    !(wr_fire && rd_fire && (wr_bank_q == rd_bank_q))
  );

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
module tb_fft_bitrev_buffer;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic        flush16;
  logic [7:0]  in16_data;
  logic        in16_valid;
  logic        in16_ready;
  logic [7:0]  out16_data;
  logic        out16_valid;
  logic        out16_ready;

`ifdef BITREV_LAST_EN
  logic        out_last;
  logic        out16_last;
`endif

  exp_t q8[$];
  exp_t q16[$];
  int   errors = 0;
  int   checks = 0;
  int   pops8  = 0;
  int   frame_buf[8];
  int   frame_n = 0;
  int   br8[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   exp16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_bitrev_buffer #(.SAMPLES(8), .ADDR_WIDTH(3), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BITREV_LAST_EN
    , .out_last(out_last)
`endif
  );

  fft_bitrev_buffer #(.SAMPLES(16), .ADDR_WIDTH(4), .DATA_WIDTH(8)) dut16 (
    .clk(clk), .reset_n(reset_n), .flush(flush16),
    .in_data(in16_data), .in_valid(in16_valid), .in_ready(in16_ready),
    .out_data(out16_data), .out_valid(out16_valid), .out_ready(out16_ready)
`ifdef BITREV_LAST_EN
    , .out_last(out16_last)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected order of a completed 8-sample frame, from the hand table.
  task automatic push_frame8();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.data = frame_buf[br8[i]];
      e.last = (i == 7);
      q8.push_back(e);
    end
  endtask

  // Presents one sample; returns at posedge+1 after it is accepted.
  task automatic send(input int v, output bit stalled);
    int budget;
    bit ok;
    budget   = 0;
    ok       = 0;
    stalled  = 0;
    in_data  = 16'(v);
    in_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
      end else begin
        stalled = 1;
        budget++;
        if (budget > 200) begin
          check("send_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame_buf[frame_n] = v;
    frame_n++;
    if (frame_n == 8) begin
      push_frame8();
      frame_n = 0;
    end
  endtask

  task automatic wait_drain8();
    int budget;
    budget = 0;
    while (q8.size() != 0 && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    check("drain8_empty", q8.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop on every output handshake.
  always @(negedge clk) begin : mon8
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (q8.size() == 0) begin
        check("unexpected_out8", int'(out_data), -1);
      end else begin
        e = q8.pop_front();
        check("out8_data", int'(out_data), e.data);
`ifdef BITREV_LAST_EN
        check("out8_last", int'(out_last), int'(e.last));
`endif
        pops8++;
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (reset_n && out16_valid && out16_ready) begin
      if (q16.size() == 0) begin
        check("unexpected_out16", int'(out16_data), -1);
      end else begin
        e = q16.pop_front();
        check("out16_data", int'(out16_data), e.data);
`ifdef BITREV_LAST_EN
        check("out16_last", int'(out16_last), int'(e.last));
`endif
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    int stalls;
    int p0;
    int budget;
    exp_t e;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    flush16 = 1'b0; in16_valid = 1'b0; in16_data = '0; out16_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out16_valid", int'(out16_valid), 0);
`ifdef BITREV_LAST_EN
    check("rst_out_last", int'(out_last), 0);
`endif
    @(posedge clk);
    #1;

    // T1: single frame, latency
    for (int i = 0; i < 8; i++) begin
      send(i, st);
      if (i == 6) check("t1_valid_before_last", int'(out_valid), 0);
      if (i == 7) check("t1_valid_after_last", int'(out_valid), 1);
    end
    wait_drain8();

    // T2: three back-to-back frames, no input stall
    stalls = 0;
    for (int i = 0; i < 24; i++) begin
      send(i, st);
      stalls += int'(st);
    end
    check("t2_in_ready_stalls", stalls, 0);
    wait_drain8();

    // T3: downstream stalled while two frames arrive
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(i, st);
    check("t3_in_ready_low", int'(in_ready), 0);
    check("t3_out_valid", int'(out_valid), 1);
    check("t3_out_data_hold0", int'(out_data), 0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_out_valid_hold", int'(out_valid), 1);
    check("t3_out_data_hold1", int'(out_data), 0);
    out_ready = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("t3_in_ready_still_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check("t3_in_ready_back", int'(in_ready), 1);
    wait_drain8();

    // T4: flush after a partial frame; sample presented with flush is dropped
    for (int i = 0; i < 5; i++) send(100 + i, st);
    in_data  = 16'd999;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    frame_n  = 0;
    check("t4_out_valid_after_flush", int'(out_valid), 0);
    check("t4_in_ready_after_flush", int'(in_ready), 1);
    for (int i = 0; i < 8; i++) send(i, st);
    wait_drain8();

    // T5: asynchronous reset while draining
    p0 = pops8;
    for (int i = 0; i < 8; i++) send(200 + i, st);
    budget = 0;
    while (pops8 < p0 + 3 && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check("t5_reached_index3", int'(pops8 >= p0 + 3), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_out_valid_in_reset", int'(out_valid), 0);
    check("t5_in_ready_in_reset", int'(in_ready), 1);
    q8.delete();
    frame_n = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_out_valid_after_reset", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) send(50 + i, st);
    wait_drain8();

    // T6: 16-sample instance
    for (int i = 0; i < 16; i++) begin
      e.data = exp16[i];
      e.last = (i == 15);
      q16.push_back(e);
    end
    @(negedge clk);
    check("t6_in16_ready", int'(in16_ready), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      in16_data  = 8'(i);
      in16_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in16_valid = 1'b0;
    budget = 0;
    while (q16.size() != 0 && budget < 300) begin
      @(posedge clk);
      budget++;
    end
    check("drain16_empty", q16.size(), 0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
